// File: rtl/jesd204_versal_gt_tx_lane_seq.sv
// Per-lane JESD204 TX start-up sequencer: idles the GT lane until reset-done has settled, then passes link data.
// One register stage in every state; no backpressure (link_ready gates the link layer). Option macro: JESD204_TX_PRBS_EN.
module jesd204_versal_gt_tx_lane_seq #(
  parameter int LINK_MODE     = 2,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic        usr_clk,
  input  logic        reset,
  input  logic        gt_tx_resetdone,
  input  logic        link_enable,
  input  logic [63:0] link_tx_data,
  input  logic [1:0]  link_tx_header,
  input  logic [3:0]  link_tx_charisk,
`ifdef JESD204_TX_PRBS_EN
  input  logic        prbs_enable,
`endif
  output logic [63:0] tx_data,
  output logic [1:0]  tx_header,
  output logic [3:0]  tx_charisk,
  output logic        link_ready,
  output logic [1:0]  seq_state,
  output logic [7:0]  restart_cnt
);

  localparam bit          MODE_64B66B = (LINK_MODE == 2);
  localparam logic [63:0] IDLE_DATA   = MODE_64B66B ? 64'h0 : 64'h0000_0000_BCBC_BCBC;
  localparam logic [1:0]  IDLE_HDR    = MODE_64B66B ? 2'b10 : 2'b00;
  localparam logic [3:0]  IDLE_CK     = MODE_64B66B ? 4'h0 : 4'hF;
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_SETTLE    = 2'd2,
    ST_ACTIVE    = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] settle_cnt, settle_cnt_nxt;
  logic        sync_meta, done_s;
  logic        abort;
  logic [63:0] data_nxt;
  logic [1:0]  hdr_nxt;
  logic [3:0]  ck_nxt;

  // The synchroniser only starts once the sequencer leaves RESET, so a
  // reset-done level captured before that is never acted upon.
  always_ff @(posedge usr_clk) begin
    if (reset || state == ST_RESET) begin
      sync_meta <= 1'b0;
      done_s    <= 1'b0;
    end else begin
      sync_meta <= gt_tx_resetdone;
      done_s    <= sync_meta;
    end
  end

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    abort          = !done_s || !link_enable;
    case (state)
      ST_RESET: state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (!abort) begin
          state_nxt      = ST_SETTLE;
          settle_cnt_nxt = 16'd0;
        end
      end
      ST_SETTLE: begin
        // abort takes priority over settle completion
        if (abort) begin
          state_nxt = ST_WAIT_DONE;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_nxt = ST_ACTIVE;
        end else begin
          settle_cnt_nxt = settle_cnt + 16'd1;
        end
      end
      ST_ACTIVE: begin
        if (abort) state_nxt = ST_WAIT_DONE;
      end
      default: state_nxt = ST_RESET;
    endcase
  end

`ifdef JESD204_TX_PRBS_EN
  localparam int PRBS_W = MODE_64B66B ? 64 : 32;

  logic [30:0] lfsr, lfsr_adv;
  logic [63:0] prbs_word;

  // PRBS31 (x^31+x^28+1), oldest bit first in the word MSB.
  always_comb begin
    lfsr_adv  = lfsr;
    prbs_word = '0;
    for (int i = 0; i < PRBS_W; i++) begin
      prbs_word[PRBS_W-1-i] = lfsr_adv[30] ^ lfsr_adv[27];
      lfsr_adv              = {lfsr_adv[29:0], lfsr_adv[30] ^ lfsr_adv[27]};
    end
  end

  always_ff @(posedge usr_clk) begin
    if (reset || state_nxt != ST_ACTIVE) lfsr <= '1;
    else                                 lfsr <= lfsr_adv;
  end
`endif

  // Selection uses the next state so tx_* and link_ready switch on the same edge.
  always_comb begin
    data_nxt = IDLE_DATA;
    hdr_nxt  = IDLE_HDR;
    ck_nxt   = IDLE_CK;
    if (state_nxt == ST_ACTIVE) begin
      if (MODE_64B66B) begin
        data_nxt = link_tx_data;
        hdr_nxt  = link_tx_header;
        ck_nxt   = 4'h0;
      end else begin
        data_nxt = {32'h0, link_tx_data[31:0]};
        hdr_nxt  = 2'b00;
        ck_nxt   = link_tx_charisk;
      end
`ifdef JESD204_TX_PRBS_EN
      if (prbs_enable) begin
        data_nxt = prbs_word;
        hdr_nxt  = MODE_64B66B ? 2'b01 : 2'b00;
        ck_nxt   = 4'h0;
      end
`endif
    end
  end

  always_ff @(posedge usr_clk) begin
    if (reset) begin
      state       <= ST_RESET;
      settle_cnt  <= 16'd0;
      tx_data     <= 64'h0;
      tx_header   <= 2'b00;
      tx_charisk  <= 4'h0;
      link_ready  <= 1'b0;
      restart_cnt <= 8'd0;
    end else begin
      state       <= state_nxt;
      settle_cnt  <= settle_cnt_nxt;
      tx_data     <= data_nxt;
      tx_header   <= hdr_nxt;
      tx_charisk  <= ck_nxt;
      link_ready  <= (state_nxt == ST_ACTIVE);
      if (state == ST_ACTIVE && state_nxt == ST_WAIT_DONE && restart_cnt != 8'hFF)
        restart_cnt <= restart_cnt + 8'd1;
    end
  end

  assign seq_state = state;

endmodule
